// File: rtl/spi_temp_master_multi.sv
// SPI read master for MAX31855-class converters: one chip select per sensor,
// captures a FRAME_W-bit MSB-first word on request or in a round-robin scan.
module spi_temp_master_multi #(
    parameter int FRAME_W   = 32,
    parameter int N_CH      = 4,
    parameter int CLK_DIV   = 4,
    parameter int CS_GAP    = 8,
    parameter int FAULT_BIT = 16,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CH_W-1:0]    ch_i,
    input  logic               scan_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [FRAME_W-1:0] data_o,
    output logic [CH_W-1:0]    ch_o,
    output logic               fault_o,
    output logic               spi_sck_o,
    output logic [N_CH-1:0]    spi_cs_n_o,
    input  logic               spi_miso_i,
    output logic [2:0]         state_o
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] DIV_END = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_END = BIT_W'(FRAME_W - 1);
    localparam logic [CH_W:0]    N_CH_L  = (CH_W + 1)'(N_CH);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [CH_W-1:0]    cur_ch;
    logic [CH_W-1:0]    sp;
    logic               scan_frame;

    logic               launch;
    logic [CH_W-1:0]    launch_ch;
    logic [N_CH-1:0]    cs_sel;

    assign state_o = state;

    // Scan mode takes priority and ignores the handshake inputs entirely.
    always_comb begin
        launch_ch = scan_i ? sp : ch_i;
        launch    = scan_i || (start_i && ({1'b0, ch_i} < N_CH_L));
        cs_sel    = N_CH'(1) << launch_ch;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            cur_ch     <= '0;
            sp         <= '0;
            scan_frame <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            data_o     <= '0;
            ch_o       <= '0;
            fault_o    <= 1'b0;
            spi_sck_o  <= 1'b0;
            spi_cs_n_o <= '1;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state      <= SETUP;
                        busy_o     <= 1'b1;
                        spi_cs_n_o <= ~cs_sel;
                        cur_ch     <= launch_ch;
                        scan_frame <= scan_i;
                        cnt        <= '0;
                    end else if (start_i) begin
                        err_o <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == DIV_END) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // spi_sck_o doubles as the half-period phase flag.
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (!spi_sck_o) begin
                            spi_sck_o <= 1'b1;
                        end else begin
                            spi_sck_o <= 1'b0;
                            shreg     <= {shreg[FRAME_W-2:0], spi_miso_i};
                            if (bit_cnt == BIT_END) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == DIV_END) begin
                        cnt        <= '0;
                        state      <= GAP;
                        spi_cs_n_o <= '1;
                        done_o     <= 1'b1;
                        data_o     <= shreg;
                        ch_o       <= cur_ch;
                        fault_o    <= shreg[FAULT_BIT];
                        if (scan_frame) begin
                            sp <= (sp == LAST_CH) ? '0 : sp + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_temp_master_multi.sv
// Directed bench for spi_temp_master_multi: a default-size instance (CLK_DIV=2)
// and a small FRAME_W=14 / N_CH=1 / CLK_DIV=1 instance, each with a sensor model.
module tb_spi_temp_master_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start_a, scan_a, busy_a, done_a, err_a, fault_a, sck_a;
    logic [1:0]  ch_a, cho_a;
    logic [31:0] data_a;
    logic [3:0]  cs_a;
    logic        miso_a = 1'b0;
    logic [2:0]  st_a;

    logic        start_b, scan_b, busy_b, done_b, err_b, fault_b, sck_b;
    logic [0:0]  ch_b, cho_b;
    logic [13:0] data_b;
    logic [0:0]  cs_b;
    logic        miso_b = 1'b0;
    logic [2:0]  st_b;

    spi_temp_master_multi #(.FRAME_W(32), .N_CH(4), .CLK_DIV(2), .CS_GAP(8), .FAULT_BIT(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .ch_i(ch_a), .scan_i(scan_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .data_o(data_a), .ch_o(cho_a),
        .fault_o(fault_a), .spi_sck_o(sck_a), .spi_cs_n_o(cs_a), .spi_miso_i(miso_a),
        .state_o(st_a)
    );

    spi_temp_master_multi #(.FRAME_W(14), .N_CH(1), .CLK_DIV(1), .CS_GAP(8), .FAULT_BIT(13)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .ch_i(ch_b), .scan_i(scan_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .data_o(data_b), .ch_o(cho_b),
        .fault_o(fault_b), .spi_sck_o(sck_b), .spi_cs_n_o(cs_b), .spi_miso_i(miso_b),
        .state_o(st_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Sensor model A: loads a word on CS fall, shifts on SCK fall; also measures the bus.
    logic [31:0] words_a[4];
    logic [31:0] tx_a = '0;
    logic [3:0]  pcs_a = 4'hF;
    logic        psck_a = 1'b0;
    int cyc_a = 0, low_a = 0, len_a = 0, rise_a = 0, fall_a = 0, period_a = 0;
    int gapc_a = 0, gapl_a = 0, multi_a = 0;
    logic [3:0] seen_a = '0;

    always @(negedge clk) begin
        cyc_a++;
        if (pcs_a == 4'hF && cs_a != 4'hF) begin
            for (int c = 0; c < 4; c++) if (!cs_a[c]) tx_a = words_a[c];
            period_a = cyc_a - fall_a;
            fall_a   = cyc_a;
            gapl_a   = gapc_a;
            gapc_a   = 0;
            low_a    = 1;
        end else begin
            if (psck_a && !sck_a) tx_a = tx_a << 1;
            if (cs_a != 4'hF) low_a++;
        end
        if (cs_a == 4'hF && pcs_a != 4'hF) len_a = low_a;
        if (cs_a == 4'hF && busy_a) gapc_a++;
        if (sck_a && !psck_a) rise_a++;
        if ($countones(~cs_a) > 1) multi_a++;
        seen_a = seen_a | ~cs_a;
        miso_a = tx_a[31];
        pcs_a  = cs_a;
        psck_a = sck_a;
    end

    // Sensor model B, same behaviour for the single-channel 14-bit instance.
    logic [13:0] word_b = 14'h2C35;
    logic [13:0] tx_b = '0;
    logic        pcs_b = 1'b1;
    logic        psck_b = 1'b0;
    int low_b = 0, len_b = 0, rise_b = 0;
    logic seen_b = 1'b0;

    always @(negedge clk) begin
        if (pcs_b && !cs_b[0]) begin
            tx_b  = word_b;
            low_b = 1;
        end else begin
            if (psck_b && !sck_b) tx_b = tx_b << 1;
            if (!cs_b[0]) low_b++;
        end
        if (cs_b[0] && !pcs_b) len_b = low_b;
        if (sck_b && !psck_b) rise_b++;
        seen_b = seen_b | ~cs_b[0];
        miso_b = tx_b[13];
        pcs_b  = cs_b[0];
        psck_b = sck_b;
    end

    task automatic wait_done(input bit sel_b, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sel_b ? done_b : done_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    bit ok;
    int n_busy, n_done;

    initial begin
        words_a[0] = 32'h0001_0001;
        words_a[1] = 32'h1234_5678;
        words_a[2] = 32'h0190_1A40;
        words_a[3] = 32'hCAFE_0003;
        rst = 1'b1;
        start_a = 0; ch_a = '0; scan_a = 0;
        start_b = 0; ch_b = '0; scan_b = 0;
        repeat (3) tick();
        check("rst_cs_a", cs_a, 4'hF);
        check("rst_sck_a", sck_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_state_a", st_a, 0);
        check("rst_cs_b", cs_b, 1);
        rst = 1'b0;
        tick();

        // Handshake capture on channel 2.
        rise_a = 0; seen_a = '0; multi_a = 0;
        start_a = 1; ch_a = 2'd2;
        tick();
        start_a = 0;
        check("t1_cs_low", cs_a, 4'b1011);
        check("t1_busy", busy_a, 1);
        wait_done(1'b0, 400, ok);
        check("t1_done_seen", ok, 1);
        check("t1_data", data_a, 32'h0190_1A40);
        check("t1_ch", cho_a, 2);
        check("t1_fault", fault_a, 0);
        check("t1_cs_len", len_a, 132);
        check("t1_sck_rises", rise_a, 32);
        check("t1_cs_seen", seen_a, 4'b0100);
        check("t1_cs_onehot", multi_a, 0);
        check("t1_cs_high_at_done", cs_a, 4'hF);
        n_busy = 1; n_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done_a) n_done++;
            if (busy_a) n_busy++;
            else break;
        end
        check("t1_gap_busy", n_busy, 8);
        check("t1_done_once", n_done, 0);

        // Fault bit set on channel 0.
        start_a = 1; ch_a = 2'd0;
        tick();
        start_a = 0;
        wait_done(1'b0, 400, ok);
        check("t2_done_seen", ok, 1);
        check("t2_data", data_a, 32'h0001_0001);
        check("t2_fault", fault_a, 1);
        check("t2_ch", cho_a, 0);
        repeat (10) tick();

        // Out-of-range channel on the single-channel instance.
        seen_b = 1'b0;
        start_b = 1; ch_b = 1'b1;
        tick();
        start_b = 0;
        check("t3_err", err_b, 1);
        check("t3_busy", busy_b, 0);
        tick();
        check("t3_err_pulse", err_b, 0);
        repeat (5) tick();
        check("t3_no_cs", seen_b, 0);
        check("t3_busy_after", busy_b, 0);

        // Round-robin scan over nine frames.
        for (int k = 0; k < 9; k++) exp_q.push_back({30'd0, 2'(k % 4), words_a[k % 4]});
        scan_a = 1;
        for (int k = 0; k < 9; k++) begin
            logic [63:0] e;
            wait_done(1'b0, 400, ok);
            if (k == 8) scan_a = 0;
            check($sformatf("t4_done_seen_%0d", k), ok, 1);
            e = exp_q.pop_front();
            check($sformatf("t4_data_%0d", k), data_a, e[31:0]);
            check($sformatf("t4_ch_%0d", k), cho_a, e[33:32]);
            if (k > 0) begin
                check($sformatf("t4_period_%0d", k), period_a, 141);
                check($sformatf("t4_gap_%0d", k), gapl_a, 8);
            end
        end
        repeat (30) tick();
        check("t4_stopped_busy", busy_a, 0);
        check("t4_stopped_cs", cs_a, 4'hF);

        // Reset in the middle of the shift phase, then a clean frame.
        rise_a = 0;
        start_a = 1; ch_a = 2'd1;
        tick();
        start_a = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rise_a >= 10) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_reached_bit10", ok, 1);
        rst = 1'b1;
        tick();
        check("t5_cs", cs_a, 4'hF);
        check("t5_sck", sck_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_done", done_a, 0);
        check("t5_data", data_a, 0);
        check("t5_ch", cho_a, 0);
        check("t5_fault", fault_a, 0);
        check("t5_state", st_a, 0);
        rst = 1'b0;
        tick();
        start_a = 1; ch_a = 2'd3;
        tick();
        start_a = 0;
        wait_done(1'b0, 400, ok);
        check("t5_done_seen", ok, 1);
        check("t5_clean_data", data_a, 32'hCAFE_0003);
        check("t5_clean_ch", cho_a, 3);
        check("t5_clean_len", len_a, 132);

        // Small instance: 14-bit frame, CLK_DIV=1.
        rise_b = 0;
        start_b = 1; ch_b = 1'b0;
        tick();
        start_b = 0;
        wait_done(1'b1, 200, ok);
        check("t6_done_seen", ok, 1);
        check("t6_data", data_b, 14'h2C35);
        check("t6_fault", fault_b, 1);
        check("t6_ch", cho_b, 0);
        check("t6_cs_len", len_b, 30);
        check("t6_sck_rises", rise_b, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
